round_sequencer: RTL and testbench
==================================

// Module: round_sequencer
// PURPOSE
//  Game-level controller for the quadrant-guess VGA game. Requests a random target
//  quadrant and gates the sprite display for a timed window. Then opens a timed guess
//  window, judges the player's selection, and keeps score/lives until game over.
//  Drives the step code consumed by the sprite, comparator and overlay logic.
// PARAMETERS
//  TICK_DIV    50_000_000  clk cycles per 1 s tick (internal prescaler)
//  SHOW_SECS   3           seconds the target sprite is shown
//  GUESS_SECS  5           seconds allowed for the player's selection
//  RESULT_SECS 2           seconds the win/lose indication is held
//  LIVES       3           lives at game start (1..3)
//  WIN_SCORE   9           score that ends the game as won (1..15)
//  NQUAD       4           valid quadrants are 0..NQUAD-1
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  start_pulse  in   1  debounced 1-cycle start request
//  select_pulse in   1  debounced 1-cycle player select
//  player_quad  in   3  quadrant currently highlighted by the player
//  rand_ready   in   1  random source has a valid value on rand_quad
//  rand_quad    in   3  random quadrant
//  rand_req     out  1  request random value (level)
//  target_quad  out  3  captured target quadrant
//  step         out  4  game phase code (game_pkg)
//  sprite_en    out  1  target sprite visible
//  round_win    out  1  held during RESULT after a hit
//  round_lose   out  1  held during RESULT after a miss or timeout
//  game_over    out  1  in OVER state; game_won  out 1  OVER reached via WIN_SCORE
//  score        out  4  hits this game;  lives  out 2  remaining lives
//  secs_left    out  4  whole seconds left in current timed state, else 0
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, except step=STEP_IDLE. All flag outputs are registered.
//  Prescaler: counts 0..TICK_DIV-1 and pulses tick on the wrap. It is cleared on every
//    state entry, so the first second of each timed state is a full TICK_DIV cycles.
//  IDLE: start_pulse -> ROLL; score<=0, lives<=LIVES, game_won<=0.
//  ROLL: rand_req=1. On rand_ready with rand_quad<NQUAD: target_quad<=rand_quad,
//    rand_req drops the next cycle, -> SHOW, secs_left<=SHOW_SECS. If rand_quad>=NQUAD,
//    the value is discarded and rand_req stays high.
//  SHOW: sprite_en=1. On each tick secs_left decrements; a tick with secs_left==1
//    -> GUESS, secs_left<=GUESS_SECS. select_pulse is ignored.
//  GUESS: select_pulse -> JUDGE, capturing player_quad. A tick with secs_left==1 means
//    timeout -> JUDGE as a miss. If select and timeout coincide, the select wins.
//  JUDGE (1 cycle): hit = !timeout && captured==target_quad.
//    On a hit, score increments and saturates at 15. On a miss, lives decrements
//    (floor 0). -> RESULT, secs_left<=RESULT_SECS.
//  RESULT: round_win/round_lose held. A tick with secs_left==1 decides the next state:
//    lives==0 -> OVER. score>=WIN_SCORE -> OVER with game_won=1. Otherwise -> ROLL.
//  OVER: game_over=1; score/lives frozen; start_pulse -> ROLL with a fresh game
//    (score 0, lives LIVES, game_won 0).
//  start_pulse is ignored outside IDLE/OVER. An rst mid-game returns to reset values
//    in the next cycle, drops rand_req and discards the target.
//  step codes: IDLE=0 ROLL=1 SHOW=2 GUESS=3 JUDGE=4 RESULT=5 OVER=6.
// STRUCTURE
//  game_pkg: state_t enum, STEP_* 4-bit constants, QUAD_W=3.
//  Sub-module tick_prescaler (clk, rst, clear, tick; param TICK_DIV).
//  Remainder: one FSM always_ff plus registered output decode.
// TESTING (TICK_DIV=4, SHOW 2, GUESS 3, RESULT 1, LIVES 2, WIN_SCORE 2)
//  1 Reset, then start; rand_ready=1 with quad 2 -> target_quad=2, SHOW with sprite_en
//    high for exactly 8 cycles, then GUESS.
//  2 Select with player_quad=2 -> JUDGE 1 cycle, round_win, score=1; RESULT 4 cycles -> ROLL.
//  3 Second hit -> after RESULT: game_over=1, game_won=1, score=2.
//  4 No select in GUESS -> timeout after 12 cycles, round_lose, lives 2->1; repeat ->
//    lives=0, game_over=1, game_won=0.
//  5 rand_quad=5 with rand_ready -> stays in ROLL with rand_req=1; then quad 1 -> accepted.
//  6 Select on the timeout tick counts as a guess. rst asserted in SHOW -> next cycle
//    step=0, all outputs 0. start_pulse during GUESS -> ignored.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, step codes and quadrant width for the quadrant-guess game.
package game_pkg;
    localparam int QUAD_W = 3;
    typedef enum logic [2:0] {
        S_IDLE, S_ROLL, S_SHOW, S_GUESS, S_JUDGE, S_RESULT, S_OVER
    } state_t;
    localparam logic [3:0] STEP_IDLE   = 4'd0;
    localparam logic [3:0] STEP_ROLL   = 4'd1;
    localparam logic [3:0] STEP_SHOW   = 4'd2;
    localparam logic [3:0] STEP_GUESS  = 4'd3;
    localparam logic [3:0] STEP_JUDGE  = 4'd4;
    localparam logic [3:0] STEP_RESULT = 4'd5;
    localparam logic [3:0] STEP_OVER   = 4'd6;
    // State encoding is ordered to coincide with the step codes.
    function automatic logic [3:0] step_of(state_t s);
        return {1'b0, s};
    endfunction
endpackage

// File: rtl/round_sequencer_if.sv
// round_sequencer_if: player/random-source inputs and game status outputs of the round sequencer.
interface round_sequencer_if;
    logic                      start_pulse;
    logic                      select_pulse;
    logic [game_pkg::QUAD_W-1:0] player_quad;
    logic                      rand_ready;
    logic [game_pkg::QUAD_W-1:0] rand_quad;
    logic                      rand_req;
    logic [game_pkg::QUAD_W-1:0] target_quad;
    logic [3:0]                step;
    logic                      sprite_en;
    logic                      round_win;
    logic                      round_lose;
    logic                      game_over;
    logic                      game_won;
    logic [3:0]                score;
    logic [1:0]                lives;
    logic [3:0]                secs_left;
    modport master (
        input  start_pulse, select_pulse, player_quad, rand_ready, rand_quad,
        output rand_req, target_quad, step, sprite_en, round_win, round_lose,
               game_over, game_won, score, lives, secs_left
    );
    modport slave (
        output start_pulse, select_pulse, player_quad, rand_ready, rand_quad,
        input  rand_req, target_quad, step, sprite_en, round_win, round_lose,
               game_over, game_won, score, lives, secs_left
    );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every TICK_DIV clocks; clear restarts a full period.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick  = cnt_q == CW'(TICK_DIV - 1);
    assign cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: round/score/lives controller driving the sprite, guess window and result display.
module round_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int SHOW_SECS   = 3,
    parameter int GUESS_SECS  = 5,
    parameter int RESULT_SECS = 2,
    parameter int LIVES       = 3,
    parameter int WIN_SCORE   = 9,
    parameter int NQUAD       = 4
) (
    input logic              clk,
    input logic              rst,
    round_sequencer_if.master bus
);
    state_t              state_q, state_d;
    logic [QUAD_W-1:0]   target_q, target_d, guess_q, guess_d;
    logic                timeout_q, timeout_d, win_q, win_d, lose_q, lose_d, won_q, won_d;
    logic [3:0]          score_q, score_d, secs_q, secs_d, step_q;
    logic [1:0]          lives_q, lives_d;
    logic                rand_req_q, sprite_q, over_q, tick, hit;
    // Every state change restarts the prescaler so each timed second is full length.
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk(clk), .rst(rst), .clear(state_d != state_q), .tick(tick)
    );
    assign hit = !timeout_q && guess_q == target_q;
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        guess_d   = guess_q;
        timeout_d = timeout_q;
        win_d     = win_q;
        lose_d    = lose_q;
        won_d     = won_q;
        score_d   = score_q;
        lives_d   = lives_q;
        secs_d    = secs_q;
        case (state_q)
            S_IDLE, S_OVER: if (bus.start_pulse) begin
                state_d = S_ROLL;
                score_d = '0;
                lives_d = 2'(LIVES);
                won_d   = 1'b0;
            end
            S_ROLL: if (bus.rand_ready && int'(bus.rand_quad) < NQUAD) begin
                target_d = bus.rand_quad;
                state_d  = S_SHOW;
                secs_d   = 4'(SHOW_SECS);
            end
            S_SHOW: if (tick) begin
                state_d = secs_q == 4'd1 ? S_GUESS : S_SHOW;
                secs_d  = secs_q == 4'd1 ? 4'(GUESS_SECS) : secs_q - 4'd1;
            end
            S_GUESS: if (bus.select_pulse) begin
                guess_d   = bus.player_quad;
                timeout_d = 1'b0;
                state_d   = S_JUDGE;
                secs_d    = '0;
            end else if (tick) begin
                secs_d    = secs_q - 4'd1;
                timeout_d = secs_q == 4'd1;
                state_d   = secs_q == 4'd1 ? S_JUDGE : S_GUESS;
            end
            S_JUDGE: begin
                score_d = hit && score_q != 4'd15 ? score_q + 4'd1 : score_q;
                lives_d = !hit && lives_q != 2'd0 ? lives_q - 2'd1 : lives_q;
                win_d   = hit;
                lose_d  = !hit;
                state_d = S_RESULT;
                secs_d  = 4'(RESULT_SECS);
            end
            S_RESULT: if (tick) begin
                secs_d = secs_q - 4'd1;
                if (secs_q == 4'd1) begin
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    won_d   = lives_q != 2'd0 && score_q >= 4'(WIN_SCORE);
                    state_d = (lives_q == 2'd0 || score_q >= 4'(WIN_SCORE)) ? S_OVER : S_ROLL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            guess_q    <= '0;
            timeout_q  <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            won_q      <= 1'b0;
            score_q    <= '0;
            lives_q    <= '0;
            secs_q     <= '0;
            step_q     <= STEP_IDLE;
            rand_req_q <= 1'b0;
            sprite_q   <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            guess_q    <= guess_d;
            timeout_q  <= timeout_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            won_q      <= won_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            secs_q     <= secs_d;
            step_q     <= step_of(state_d);
            rand_req_q <= state_d == S_ROLL;
            sprite_q   <= state_d == S_SHOW;
            over_q     <= state_d == S_OVER;
        end
    end
    assign bus.rand_req    = rand_req_q;
    assign bus.target_quad = target_q;
    assign bus.step        = step_q;
    assign bus.sprite_en   = sprite_q;
    assign bus.round_win   = win_q;
    assign bus.round_lose  = lose_q;
    assign bus.game_over   = over_q;
    assign bus.game_won    = won_q;
    assign bus.score       = score_q;
    assign bus.lives       = lives_q;
    assign bus.secs_left   = secs_q;
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed game scenarios with a short tick (4 clocks per second).
module tb_round_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n;
    round_sequencer_if bus ();
    round_sequencer #(
        .TICK_DIV(4), .SHOW_SECS(2), .GUESS_SECS(3), .RESULT_SECS(1),
        .LIVES(2), .WIN_SCORE(2), .NQUAD(4)
    ) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    // Counts cycles spent with step == s, giving up after 100.
    task automatic dwell(input logic [3:0] s, output int cnt);
        cnt = 0;
        while (bus.step == s && cnt < 100) begin
            cnt++;
            cyc();
        end
    endtask
    initial begin
        bus.start_pulse  = 1'b0;
        bus.select_pulse = 1'b0;
        bus.player_quad  = '0;
        bus.rand_ready   = 1'b0;
        bus.rand_quad    = '0;
        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_step", bus.step, 0);
        chk("reset_rand_req", bus.rand_req, 0);
        chk("reset_lives", bus.lives, 0);
        chk("reset_score", bus.score, 0);
        chk("reset_over", bus.game_over, 0);
        // Round 1: target 2, sprite shown for 2 s = 8 clocks
        bus.rand_ready = 1'b1;
        bus.rand_quad  = 3'd2;
        bus.start_pulse = 1'b1;
        cyc();
        bus.start_pulse = 1'b0;
        chk("start_roll", bus.step, 1);
        chk("roll_req", bus.rand_req, 1);
        chk("start_lives", bus.lives, 2);
        cyc();
        bus.rand_ready = 1'b0;
        chk("show_step", bus.step, 2);
        chk("show_target", bus.target_quad, 2);
        chk("show_req_drop", bus.rand_req, 0);
        chk("show_secs", bus.secs_left, 2);
        n = 0;
        while (bus.sprite_en && n < 50) begin
            n++;
            cyc();
        end
        chk("sprite_cycles", n, 8);
        chk("guess_step", bus.step, 3);
        chk("guess_secs", bus.secs_left, 3);
        bus.start_pulse = 1'b1;
        cyc();
        bus.start_pulse = 1'b0;
        chk("start_ignored", bus.step, 3);
        bus.player_quad  = 3'd2;
        bus.select_pulse = 1'b1;
        cyc();
        bus.select_pulse = 1'b0;
        chk("judge_step", bus.step, 4);
        cyc();
        chk("result_step", bus.step, 5);
        chk("result_win", bus.round_win, 1);
        chk("result_lose", bus.round_lose, 0);
        chk("result_score", bus.score, 1);
        dwell(4'd5, n);
        chk("result_cycles", n, 4);
        chk("back_roll", bus.step, 1);
        chk("win_cleared", bus.round_win, 0);
        // Round 2: second hit reaches WIN_SCORE
        bus.rand_ready = 1'b1;
        bus.rand_quad  = 3'd3;
        cyc();
        bus.rand_ready = 1'b0;
        chk("r2_target", bus.target_quad, 3);
        dwell(4'd2, n);
        bus.player_quad  = 3'd3;
        bus.select_pulse = 1'b1;
        cyc();
        bus.select_pulse = 1'b0;
        cyc();
        dwell(4'd5, n);
        chk("won_step", bus.step, 6);
        chk("won_over", bus.game_over, 1);
        chk("won_flag", bus.game_won, 1);
        chk("won_score", bus.score, 2);
        chk("won_lives", bus.lives, 2);
        // New game from OVER; two timeouts exhaust the lives
        bus.start_pulse = 1'b1;
        cyc();
        bus.start_pulse = 1'b0;
        chk("new_game_score", bus.score, 0);
        chk("new_game_won", bus.game_won, 0);
        chk("new_game_over", bus.game_over, 0);
        bus.rand_ready = 1'b1;
        bus.rand_quad  = 3'd0;
        cyc();
        bus.rand_ready = 1'b0;
        dwell(4'd2, n);
        dwell(4'd3, n);
        chk("timeout_cycles", n, 12);
        chk("timeout_judge", bus.step, 4);
        cyc();
        chk("timeout_lose", bus.round_lose, 1);
        chk("timeout_win", bus.round_win, 0);
        chk("timeout_lives", bus.lives, 1);
        dwell(4'd5, n);
        // Out-of-range random value is discarded
        bus.rand_ready = 1'b1;
        bus.rand_quad  = 3'd5;
        cyc();
        chk("bad_quad_step", bus.step, 1);
        chk("bad_quad_req", bus.rand_req, 1);
        cyc();
        chk("bad_quad_step2", bus.step, 1);
        bus.rand_quad = 3'd1;
        cyc();
        bus.rand_ready = 1'b0;
        chk("good_quad_step", bus.step, 2);
        chk("good_quad_target", bus.target_quad, 1);
        dwell(4'd2, n);
        dwell(4'd3, n);
        cyc();
        chk("lose2_lives", bus.lives, 0);
        dwell(4'd5, n);
        chk("lost_step", bus.step, 6);
        chk("lost_over", bus.game_over, 1);
        chk("lost_won", bus.game_won, 0);
        // Select arriving on the timeout tick is a real guess
        bus.start_pulse = 1'b1;
        cyc();
        bus.start_pulse = 1'b0;
        bus.rand_ready = 1'b1;
        bus.rand_quad  = 3'd2;
        cyc();
        bus.rand_ready = 1'b0;
        dwell(4'd2, n);
        for (int i = 0; i < 11; i++) cyc();
        chk("last_sec_step", bus.step, 3);
        chk("last_sec_secs", bus.secs_left, 1);
        bus.player_quad  = 3'd2;
        bus.select_pulse = 1'b1;
        cyc();
        bus.select_pulse = 1'b0;
        cyc();
        chk("edge_select_win", bus.round_win, 1);
        chk("edge_select_score", bus.score, 1);
        dwell(4'd5, n);
        // Reset in the middle of SHOW
        bus.rand_ready = 1'b1;
        bus.rand_quad  = 3'd3;
        cyc();
        bus.rand_ready = 1'b0;
        cyc();
        chk("pre_rst_sprite", bus.sprite_en, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_step", bus.step, 0);
        chk("rst_sprite", bus.sprite_en, 0);
        chk("rst_target", bus.target_quad, 0);
        chk("rst_score", bus.score, 0);
        chk("rst_lives", bus.lives, 0);
        chk("rst_secs", bus.secs_left, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
